// File: rtl/ddp_recv_buffer_pkg.sv
// rtl/ddp_recv_buffer_pkg.sv - shared constants for the DDP cut / receive buffer / DMA stages
package ddp_recv_buffer_pkg;

    localparam int QN_W      = 4;
    localparam int NUM_QUEUE = 16;
    localparam int DATA_W    = 256;
    localparam int AW        = 4;
    localparam int RAM_AW    = QN_W + AW;

    typedef logic [AW:0]     ptr_t;
    typedef logic [QN_W-1:0] qn_t;

    // A queue is full when the wrap bits differ and the slot indices match.
    function automatic logic ptr_full(input ptr_t wr, input ptr_t rd);
        return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    endfunction

endpackage

// File: rtl/ddp_rb_sdpram.sv
// rtl/ddp_rb_sdpram.sv - simple dual-port RAM, one write port, one registered read port
module ddp_rb_sdpram #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 256
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ADDR_W];
    logic [WIDTH-1:0] r_rdata;

    // Write port: array has no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: output register is only loaded on an accepted read.
    always_ff @(posedge clock) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ddp_recv_buffer.sv
// rtl/ddp_recv_buffer.sv - per-queue receive buffer: NUM_QUEUE circular FIFOs in one shared RAM
module ddp_recv_buffer
    import ddp_recv_buffer_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_push,
    input  logic [QN_W-1:0]      i_qn,
    input  logic [DATA_W-1:0]    i_push_data,
    input  logic                 i_rd_req,
    input  logic [QN_W-1:0]      i_rd_qn,
    output logic [DATA_W-1:0]    o_rd_data,
    output logic                 o_rd_valid,
    output logic [AW:0]          o_rd_count,
    output logic [NUM_QUEUE-1:0] o_q_empty,
    output logic [NUM_QUEUE-1:0] o_q_full,
    input  logic                 i_flush,
    input  logic [QN_W-1:0]      i_flush_qn,
    output logic                 o_overflow,
    output logic [QN_W-1:0]      o_overflow_qn
);

    localparam ptr_t PTR_ONE = ptr_t'(1);

    ptr_t r_wr_ptr [NUM_QUEUE];
    ptr_t r_rd_ptr [NUM_QUEUE];

    logic            r_rd_valid;
    logic            r_overflow;
    logic [QN_W-1:0] r_overflow_qn;

    logic [NUM_QUEUE-1:0] w_empty;
    logic [NUM_QUEUE-1:0] w_full;
    ptr_t                 w_push_wr_ptr;
    ptr_t                 w_rd_wr_ptr;
    ptr_t                 w_rd_rd_ptr;
    logic                 w_push_flushed;
    logic                 w_rd_flushed;
    logic                 w_push_ok;
    logic                 w_push_drop;
    logic                 w_rd_ok;
    logic [RAM_AW-1:0]    w_waddr;
    logic [RAM_AW-1:0]    w_raddr;

    // Per-queue flags from the pre-edge pointer state; no push/read bypass.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int q = 0; q < NUM_QUEUE; q++) begin
            w_empty[q] = (r_wr_ptr[q] == r_rd_ptr[q]);
            w_full[q]  = ptr_full(r_wr_ptr[q], r_rd_ptr[q]);
        end
    end

    assign w_push_wr_ptr = r_wr_ptr[i_qn];
    assign w_rd_wr_ptr   = r_wr_ptr[i_rd_qn];
    assign w_rd_rd_ptr   = r_rd_ptr[i_rd_qn];

    // A flush of the same queue swallows a push (silently) and a read.
    assign w_push_flushed = i_flush && (i_flush_qn == i_qn);
    assign w_rd_flushed   = i_flush && (i_flush_qn == i_rd_qn);

    assign w_push_ok   = i_push && !w_full[i_qn] && !w_push_flushed;
    assign w_push_drop = i_push &&  w_full[i_qn] && !w_push_flushed;
    assign w_rd_ok     = i_rd_req && !w_empty[i_rd_qn] && !w_rd_flushed;

    assign w_waddr = {i_qn,    w_push_wr_ptr[AW-1:0]};
    assign w_raddr = {i_rd_qn, w_rd_rd_ptr[AW-1:0]};

    ddp_rb_sdpram #(
        .ADDR_W (RAM_AW),
        .WIDTH  (DATA_W)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_push_ok),
        .i_waddr (w_waddr),
        .i_wdata (i_push_data),
        .i_re    (w_rd_ok),
        .i_raddr (w_raddr),
        .o_rdata (o_rd_data)
    );

    // Pointer update; flush is applied last so it overrides any same-edge increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int q = 0; q < NUM_QUEUE; q++) begin
                r_wr_ptr[q] <= '0;
                r_rd_ptr[q] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_wr_ptr[i_qn] <= w_push_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr[i_rd_qn] <= w_rd_rd_ptr + PTR_ONE;
            end
            if (i_flush) begin
                r_wr_ptr[i_flush_qn] <= '0;
                r_rd_ptr[i_flush_qn] <= '0;
            end
        end
    end

    // Read-valid pipeline flop and overflow pulse / sticky queue number.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_valid    <= 1'b0;
            r_overflow    <= 1'b0;
            r_overflow_qn <= '0;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_overflow <= w_push_drop;
            if (w_push_drop) begin
                r_overflow_qn <= i_qn;
            end
        end
    end

    assign o_rd_valid    = r_rd_valid;
    assign o_overflow    = r_overflow;
    assign o_overflow_qn = r_overflow_qn;
    assign o_q_empty     = w_empty;
    assign o_q_full      = w_full;
    assign o_rd_count    = w_rd_wr_ptr - w_rd_rd_ptr;

endmodule

// File: tb/tb_ddp_recv_buffer.sv
// tb/tb_ddp_recv_buffer.sv - directed self-checking bench for ddp_recv_buffer
module tb_ddp_recv_buffer;
    import ddp_recv_buffer_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 push;
    logic [QN_W-1:0]      qn;
    logic [DATA_W-1:0]    push_data;
    logic                 rd_req;
    logic [QN_W-1:0]      rd_qn;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic [AW:0]          rd_count;
    logic [NUM_QUEUE-1:0] q_empty;
    logic [NUM_QUEUE-1:0] q_full;
    logic                 flush;
    logic [QN_W-1:0]      flush_qn;
    logic                 overflow;
    logic [QN_W-1:0]      overflow_qn;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ddp_recv_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .i_push        (push),
        .i_qn          (qn),
        .i_push_data   (push_data),
        .i_rd_req      (rd_req),
        .i_rd_qn       (rd_qn),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_rd_count    (rd_count),
        .o_q_empty     (q_empty),
        .o_q_full      (q_full),
        .i_flush       (flush),
        .i_flush_qn    (flush_qn),
        .o_overflow    (overflow),
        .o_overflow_qn (overflow_qn)
    );

    function automatic logic [DATA_W-1:0] mk(input logic [31:0] v);
        return {8{v}};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input int q, input logic [31:0] v);
        push      = 1'b1;
        qn        = QN_W'(q);
        push_data = mk(v);
        step();
        push      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) step();
        total++; if (q_empty !== 16'hFFFF) begin bad++; $display("FAIL reset_empty got=%h exp=ffff", q_empty); end
        total++; if (q_full !== 16'h0000) begin bad++; $display("FAIL reset_full got=%h exp=0000", q_full); end
        total++; if (rd_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", rd_count); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (overflow !== 1'b0 || overflow_qn !== 4'd0) begin bad++; $display("FAIL reset_overflow got=%b/%0d exp=0/0", overflow, overflow_qn); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        rd_qn = 4'd2;
        push_one(2, 32'hA1);
        push_one(2, 32'hA2);
        push_one(2, 32'hA3);
        total++; if (rd_count !== 5'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", rd_count); end
        total++; if (q_empty[2] !== 1'b0) begin bad++; $display("FAIL basic_not_empty got=%b exp=0", q_empty[2]); end
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1;
            step();
            rd_req = 1'b0;
            total++; if (rd_valid !== 1'b1 || rd_data !== mk(32'hA1 + i)) begin bad++; $display("FAIL basic_read%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data[31:0], 32'hA1 + i); end
        end
        total++; if (q_empty[2] !== 1'b1) begin bad++; $display("FAIL basic_empty_after got=%b exp=1", q_empty[2]); end
        step();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", rd_valid); end
    endtask

    task automatic test_full();
        rd_qn = 4'd5;
        for (int i = 0; i < 16; i++) push_one(5, 32'h500 + i);
        total++; if (q_full[5] !== 1'b1 || rd_count !== 5'd16) begin bad++; $display("FAIL full_flag got=%b/%0d exp=1/16", q_full[5], rd_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf_yet got=%b exp=0", overflow); end
        push_one(5, 32'h5FF);
        total++; if (overflow !== 1'b1 || overflow_qn !== 4'd5) begin bad++; $display("FAIL full_overflow got=%b/%0d exp=1/5", overflow, overflow_qn); end
        total++; if (rd_count !== 5'd16) begin bad++; $display("FAIL full_count_hold got=%0d exp=16", rd_count); end
        step();
        total++; if (overflow !== 1'b0 || overflow_qn !== 4'd5) begin bad++; $display("FAIL full_ovf_pulse got=%b/%0d exp=0/5", overflow, overflow_qn); end
        for (int i = 0; i < 16; i++) begin
            rd_req = 1'b1;
            step();
            rd_req = 1'b0;
            total++; if (rd_valid !== 1'b1 || rd_data !== mk(32'h500 + i)) begin bad++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data[31:0], 32'h500 + i); end
        end
        total++; if (q_empty[5] !== 1'b1 || q_full[5] !== 1'b0) begin bad++; $display("FAIL full_drained got=%b/%b exp=1/0", q_empty[5], q_full[5]); end
    endtask

    task automatic test_interleave();
        rd_qn = 4'd0;
        for (int i = 0; i < 32; i++) begin
            push      = 1'b1;
            qn        = (i % 2 == 1) ? 4'd15 : 4'd0;
            push_data = (i % 2 == 1) ? mk(32'h200 + i / 2) : mk(32'h100 + i / 2);
            rd_req    = 1'b1;
            step();
            total++; if (rd_valid !== (i % 2 == 1)) begin bad++; $display("FAIL inter_valid%0d got=%b exp=%b", i, rd_valid, (i % 2 == 1)); end
            if (i % 2 == 1) begin
                total++; if (rd_data !== mk(32'h100 + (i - 1) / 2)) begin bad++; $display("FAIL inter_data%0d got=%h exp=%h", i, rd_data[31:0], 32'h100 + (i - 1) / 2); end
            end
        end
        push   = 1'b0;
        rd_req = 1'b0;
        total++; if (q_empty[0] !== 1'b1 || q_full[15] !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL inter_flags got=%b/%b/%b exp=1/1/0", q_empty[0], q_full[15], overflow); end
        rd_qn = 4'd15;
        #1;
        total++; if (rd_count !== 5'd16) begin bad++; $display("FAIL inter_q15_count got=%0d exp=16", rd_count); end
        for (int k = 0; k < 16; k++) begin
            rd_req = 1'b1;
            step();
            rd_req = 1'b0;
            total++; if (rd_valid !== 1'b1 || rd_data !== mk(32'h200 + k)) begin bad++; $display("FAIL inter_q15_%0d got=%b/%h exp=1/%h", k, rd_valid, rd_data[31:0], 32'h200 + k); end
        end
    endtask

    task automatic test_same_cycle();
        rd_qn     = 4'd7;
        push      = 1'b1;
        qn        = 4'd7;
        push_data = mk(32'h700);
        rd_req    = 1'b1;
        step();
        push   = 1'b0;
        rd_req = 1'b0;
        total++; if (rd_valid !== 1'b0 || rd_count !== 5'd1) begin bad++; $display("FAIL same_empty got=%b/%0d exp=0/1", rd_valid, rd_count); end
        for (int k = 1; k < 16; k++) push_one(7, 32'h700 + k);
        total++; if (q_full[7] !== 1'b1) begin bad++; $display("FAIL same_full got=%b exp=1", q_full[7]); end
        push      = 1'b1;
        push_data = mk(32'h7FF);
        rd_req    = 1'b1;
        step();
        push   = 1'b0;
        rd_req = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== mk(32'h700)) begin bad++; $display("FAIL same_full_read got=%b/%h exp=1/700", rd_valid, rd_data[31:0]); end
        total++; if (overflow !== 1'b1 || overflow_qn !== 4'd7 || rd_count !== 5'd15) begin bad++; $display("FAIL same_full_drop got=%b/%0d/%0d exp=1/7/15", overflow, overflow_qn, rd_count); end
        for (int k = 1; k < 16; k++) begin
            rd_req = 1'b1;
            step();
            rd_req = 1'b0;
            total++; if (rd_valid !== 1'b1 || rd_data !== mk(32'h700 + k)) begin bad++; $display("FAIL same_drain%0d got=%b/%h exp=1/%h", k, rd_valid, rd_data[31:0], 32'h700 + k); end
        end
        total++; if (q_empty[7] !== 1'b1) begin bad++; $display("FAIL same_drained got=%b exp=1", q_empty[7]); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) push_one(3, 32'h300 + k);
        push_one(4, 32'h400);
        rd_qn = 4'd4;
        #1;
        total++; if (rd_count !== 5'd1) begin bad++; $display("FAIL flush_q4_pre got=%0d exp=1", rd_count); end
        flush     = 1'b1;
        flush_qn  = 4'd3;
        push      = 1'b1;
        qn        = 4'd3;
        push_data = mk(32'h3AA);
        rd_req    = 1'b1;
        rd_qn     = 4'd3;
        step();
        push   = 1'b0;
        rd_req = 1'b0;
        total++; if (rd_valid !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL flush_side got=%b/%b exp=0/0", rd_valid, overflow); end
        total++; if (q_empty[3] !== 1'b1 || rd_count !== 5'd0) begin bad++; $display("FAIL flush_q3 got=%b/%0d exp=1/0", q_empty[3], rd_count); end
        push      = 1'b1;
        qn        = 4'd4;
        push_data = mk(32'h401);
        step();
        push  = 1'b0;
        flush = 1'b0;
        rd_qn = 4'd4;
        #1;
        total++; if (rd_count !== 5'd2 || q_empty[3] !== 1'b1) begin bad++; $display("FAIL flush_q4_count got=%0d/%b exp=2/1", rd_count, q_empty[3]); end
        for (int k = 0; k < 2; k++) begin
            rd_req = 1'b1;
            step();
            rd_req = 1'b0;
            total++; if (rd_valid !== 1'b1 || rd_data !== mk(32'h400 + k)) begin bad++; $display("FAIL flush_q4_data%0d got=%b/%h exp=1/%h", k, rd_valid, rd_data[31:0], 32'h400 + k); end
        end
        push_one(3, 32'h3BB);
        rd_qn  = 4'd3;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== mk(32'h3BB)) begin bad++; $display("FAIL flush_q3_reuse got=%b/%h exp=1/3bb", rd_valid, rd_data[31:0]); end
    endtask

    task automatic test_wrap();
        rd_qn = 4'd9;
        push_one(9, 32'h900);
        for (int i = 1; i < 40; i++) begin
            push      = 1'b1;
            qn        = 4'd9;
            push_data = mk(32'h900 + i);
            rd_req    = 1'b1;
            step();
            push   = 1'b0;
            rd_req = 1'b0;
            total++; if (rd_valid !== 1'b1 || rd_data !== mk(32'h900 + i - 1) || q_full[9] !== 1'b0) begin bad++; $display("FAIL wrap%0d got=%b/%h/%b exp=1/%h/0", i, rd_valid, rd_data[31:0], q_full[9], 32'h900 + i - 1); end
        end
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== mk(32'h927) || q_empty[9] !== 1'b1) begin bad++; $display("FAIL wrap_last got=%b/%h/%b exp=1/927/1", rd_valid, rd_data[31:0], q_empty[9]); end
    endtask

    task automatic test_async_reset();
        push_one(1, 32'h111);
        push_one(1, 32'h112);
        rd_qn = 4'd1;
        #1;
        total++; if (rd_count !== 5'd2) begin bad++; $display("FAIL areset_pre got=%0d exp=2", rd_count); end
        @(negedge clock);
        push      = 1'b1;
        qn        = 4'd1;
        push_data = mk(32'h113);
        reset     = 1'b0;
        #1;
        total++; if (q_empty !== 16'hFFFF || rd_count !== 5'd0) begin bad++; $display("FAIL areset_now got=%h/%0d exp=ffff/0", q_empty, rd_count); end
        push = 1'b0;
        step();
        @(negedge clock);
        reset = 1'b1;
        step();
        total++; if (q_empty !== 16'hFFFF || rd_valid !== 1'b0 || overflow_qn !== 4'd0) begin bad++; $display("FAIL areset_after got=%h/%b/%0d exp=ffff/0/0", q_empty, rd_valid, overflow_qn); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        push      = 1'b0;
        qn        = '0;
        push_data = '0;
        rd_req    = 1'b0;
        rd_qn     = '0;
        flush     = 1'b0;
        flush_qn  = '0;
        test_reset();
        test_basic();
        test_full();
        test_interleave();
        test_same_cycle();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
